// File: rtl/cmp_seq_pkg.sv
// cmp_seq_pkg: shared types and key conversion for the sequential comparator.
// Latency: n/a (types and a pure function).
// Backpressure: n/a.
package cmp_seq_pkg;

  // Widest operand that to_key() can convert. Callers zero-extend their
  // operand to this width and keep only the low WIDTH bits of the result.
  localparam int KEY_MAX_W = 64;

  typedef enum logic [1:0] {
    MODE_UNS  = 2'b00,
    MODE_TWOS = 2'b01,
    MODE_SM   = 2'b10,
    MODE_RSV  = 2'b11
  } cmp_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_DONE = 2'd2
  } cmp_state_t;

  // Maps an operand of width w onto an unsigned key so that a plain unsigned
  // comparison of keys orders the operands correctly for the given mode.
  // The reserved mode is ordered as unsigned.
  function automatic logic [KEY_MAX_W-1:0] to_key(
    input logic [KEY_MAX_W-1:0] op,
    input int                   w,
    input cmp_mode_t            mode
  );
    logic [KEY_MAX_W-1:0] msb;
    logic [KEY_MAX_W-1:0] mask;
    logic [KEY_MAX_W-1:0] mag;
    logic [KEY_MAX_W-1:0] key;
    msb  = KEY_MAX_W'(1) << (w - 1);
    // For w == KEY_MAX_W the shift yields zero and the subtraction wraps to all ones.
    mask = (msb << 1) - KEY_MAX_W'(1);
    mag  = op & mask & ~msb;
    case (mode)
      MODE_TWOS: key = op ^ msb;
      MODE_SM: begin
        if (mag == '0)                key = msb;              // +0 and -0 collapse
        else if ((op & msb) == '0)    key = msb | mag;        // positive: {1,mag}
        else                          key = ~mag & ~msb;      // negative: {0,~mag}
      end
      default:   key = op;
    endcase
    return key & mask;
  endfunction

endpackage

// File: rtl/cmp_seq_chunk.sv
// cmp_chunk: combinational compare of one CHUNK-bit slice of the keys.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
// Ports: i_a, i_b - key slices; o_eq - slices equal; o_gt - i_a > i_b (unsigned).
module cmp_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  output logic             o_eq,
  output logic             o_gt
);

  assign o_eq = (i_a == i_b);
  assign o_gt = (i_a > i_b);

endmodule

// File: rtl/cmp_seq.sv
// cmp_seq: compares two WIDTH-bit operands (unsigned / two's complement /
//   sign-magnitude) one CHUNK-bit slice per cycle, most significant first.
// Latency: accept cycle + NCH CMP cycles, result shown in DONE; with
//   CMP_SEQ_EARLY_EXIT_EN defined, CMP ends at the first differing slice.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE,
//   so a new request can be taken no earlier than the cycle after consumption.
// Ports: clk, rst_n (async, active low); in_valid/in_ready/in_a/in_b/in_mode
//   request side; out_valid/out_ready/out_eq/out_gt/out_lt/out_err/out_cycles
//   result side (out_cycles = number of CMP cycles spent).
module cmp_seq
  import cmp_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [WIDTH-1:0]                    in_a,
  input  logic [WIDTH-1:0]                    in_b,
  input  logic [1:0]                          in_mode,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                out_eq,
  output logic                                out_gt,
  output logic                                out_lt,
  output logic                                out_err,
  output logic [$clog2(WIDTH/CHUNK):0]        out_cycles
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = $clog2(NCH) + 1;

`ifdef CMP_SEQ_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  cmp_state_t        r_state;
  cmp_state_t        w_state_nxt;
  logic [WIDTH-1:0]  r_key_a;
  logic [WIDTH-1:0]  r_key_b;
  logic              r_err;
  logic [CW-1:0]     r_cnt;      // CMP cycles completed so far
  logic              r_found;    // a differing slice has been seen
  logic              r_gt;       // direction of that first difference
  logic              r_out_eq;
  logic              r_out_gt;
  logic              r_out_lt;
  logic              r_out_err;
  logic [CW-1:0]     r_out_cycles;

  logic [KEY_MAX_W-1:0] w_key_a_full;
  logic [KEY_MAX_W-1:0] w_key_b_full;
  logic [WIDTH-1:0]     w_key_a;
  logic [WIDTH-1:0]     w_key_b;
  logic                 w_unused_key;
  logic                 w_ch_eq;
  logic                 w_ch_gt;
  logic                 w_new_diff;
  logic                 w_last;
  logic                 w_exit;

  assign w_key_a_full = to_key(KEY_MAX_W'(in_a), WIDTH, cmp_mode_t'(in_mode));
  assign w_key_b_full = to_key(KEY_MAX_W'(in_b), WIDTH, cmp_mode_t'(in_mode));
  assign w_key_a      = w_key_a_full[WIDTH-1:0];
  assign w_key_b      = w_key_b_full[WIDTH-1:0];
  // Upper bits are always zero after masking inside to_key.
  assign w_unused_key = |{w_key_a_full[KEY_MAX_W-1:WIDTH], w_key_b_full[KEY_MAX_W-1:WIDTH]};

  // Keys shift left each CMP cycle, so the slice under test is always the top one.
  cmp_chunk #(.CHUNK(CHUNK)) u_chunk (
    .i_a  (r_key_a[WIDTH-1 -: CHUNK]),
    .i_b  (r_key_b[WIDTH-1 -: CHUNK]),
    .o_eq (w_ch_eq),
    .o_gt (w_ch_gt)
  );

  assign w_new_diff = !r_found && !w_ch_eq;
  assign w_last     = (r_cnt == CW'(NCH - 1));
  assign w_exit     = w_last || (EARLY_EXIT && w_new_diff);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (in_valid)  w_state_nxt = ST_CMP;
      ST_CMP:  if (w_exit)    w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
      default:                w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_key_a      <= '0;
      r_key_b      <= '0;
      r_err        <= 1'b0;
      r_cnt        <= '0;
      r_found      <= 1'b0;
      r_gt         <= 1'b0;
      r_out_eq     <= 1'b0;
      r_out_gt     <= 1'b0;
      r_out_lt     <= 1'b0;
      r_out_err    <= 1'b0;
      r_out_cycles <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_key_a <= w_key_a;
            r_key_b <= w_key_b;
            r_err   <= (in_mode == MODE_RSV);
            r_cnt   <= '0;
            r_found <= 1'b0;
            r_gt    <= 1'b0;
          end
        end
        ST_CMP: begin
          r_key_a <= r_key_a << CHUNK;
          r_key_b <= r_key_b << CHUNK;
          if (r_cnt != CW'(NCH)) r_cnt <= r_cnt + CW'(1);
          if (w_new_diff) begin
            r_found <= 1'b1;
            r_gt    <= w_ch_gt;
          end
          if (w_exit) begin
            // Fold in the current slice: an earlier difference takes priority.
            r_out_eq     <= !r_found && w_ch_eq;
            r_out_gt     <= r_found ? r_gt  : (w_new_diff && w_ch_gt);
            r_out_lt     <= r_found ? !r_gt : (w_new_diff && !w_ch_gt);
            r_out_err    <= r_err;
            r_out_cycles <= r_cnt + CW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_eq     <= 1'b0;
            r_out_gt     <= 1'b0;
            r_out_lt     <= 1'b0;
            r_out_err    <= 1'b0;
            r_out_cycles <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready   = (r_state == ST_IDLE);
  assign out_valid  = (r_state == ST_DONE);
  assign out_eq     = r_out_eq;
  assign out_gt     = r_out_gt;
  assign out_lt     = r_out_lt;
  assign out_err    = r_out_err;
  assign out_cycles = r_out_cycles;

endmodule
